// File: rtl/time_set_ctrl.sv
// time_set_ctrl -- time-of-day register with a set mode.
//
// Holds hours/minutes/seconds. In RUN the 1 Hz tick advances the time with
// a full carry chain, and a rollover from 23:59:59 to 00:00:00 produces a
// one-cycle day_carry. btn_mode cycles RUN -> SET_HOUR -> SET_MIN -> SET_SEC
// -> RUN. While setting, the time is paused and btn_up/btn_down wrap the
// selected field within its range with no carry into neighbouring fields.
//
// Ports
//   clk        in   system clock (50 MHz)
//   rst        in   asynchronous active-high reset
//   tick       in   one-cycle 1 Hz pulse
//   tick_blink in   blink level used to flash the field being edited
//   btn_mode   in   one-cycle pulse, advances the mode
//   btn_up     in   one-cycle pulse, increments the selected field
//   btn_down   in   one-cycle pulse, decrements the selected field
//   hour       out  0..23
//   min        out  0..59
//   sec        out  0..59
//   mode       out  0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
//   blank      out  per-field blank {hour,min,sec}
//   day_carry  out  one-cycle pulse after the midnight rollover
module time_set_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       tick_blink,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] mode,
  output logic [2:0] blank,
  output logic       day_carry
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       day_carry_q, day_carry_d;

  // Modulo increment/decrement over 0..maxv. Values above maxv are folded
  // back into range so a field can never leave its legal range.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] maxv);
    return (v >= maxv) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] maxv);
    return (v == 6'd0 || v > maxv) ? maxv : v - 6'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      hour_q      <= 5'd0;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      day_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      day_carry_q <= day_carry_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    day_carry_d = 1'b0;
    // up and down together cancel out; the mode button takes priority over both.
    unique case (state_q)
      RUN: begin
        if (tick) begin
          if (sec_q >= 6'd59) begin
            sec_d = 6'd0;
            if (min_q >= 6'd59) begin
              min_d = 6'd0;
              if (hour_q >= 5'd23) begin
                hour_d      = 5'd0;
                day_carry_d = 1'b1;
              end else begin
                hour_d = hour_q + 5'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (btn_mode) state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (btn_mode) begin
          state_d = SET_MIN;
        end else if (btn_up && !btn_down) begin
          hour_d = 5'(wrap_inc({1'b0, hour_q}, 6'd23));
        end else if (btn_down && !btn_up) begin
          hour_d = 5'(wrap_dec({1'b0, hour_q}, 6'd23));
        end
      end
      SET_MIN: begin
        if (btn_mode) begin
          state_d = SET_SEC;
        end else if (btn_up && !btn_down) begin
          min_d = wrap_inc(min_q, 6'd59);
        end else if (btn_down && !btn_up) begin
          min_d = wrap_dec(min_q, 6'd59);
        end
      end
      SET_SEC: begin
        if (btn_mode) begin
          state_d = RUN;
        end else if (btn_up && !btn_down) begin
          sec_d = wrap_inc(sec_q, 6'd59);
        end else if (btn_down && !btn_up) begin
          sec_d = wrap_dec(sec_q, 6'd59);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // The field under edit flashes with tick_blink; state_q is forced to RUN
  // by reset, so blank is all-zero during reset as well.
  always_comb begin
    blank = 3'b000;
    unique case (state_q)
      SET_HOUR: blank = {tick_blink, 2'b00};
      SET_MIN:  blank = {1'b0, tick_blink, 1'b0};
      SET_SEC:  blank = {2'b00, tick_blink};
      default:  blank = 3'b000;
    endcase
  end

  assign hour      = hour_q;
  assign min       = min_q;
  assign sec       = sec_q;
  assign mode      = state_q;
  assign day_carry = day_carry_q;

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The block SHALL have the port clk  input  1  system clock, 50 MHz; the only clock.
REQ-002 The block SHALL have the port rst  input  1  reset; asynchronous, active-high.
REQ-003 The block SHALL have the port tick  input  1  one-cycle 1 Hz pulse from the tick generator.
REQ-004 The block SHALL have the port tick_blink  input  1  0.5 s-period blink level from the tick generator.
REQ-005 The block SHALL have the port btn_mode  input  1  debounced one-cycle pulse that advances the mode.
REQ-006 The block SHALL have the port btn_up  input  1  debounced one-cycle pulse that increments the selected field.
REQ-007 The block SHALL have the port btn_down  input  1  debounced one-cycle pulse that decrements the selected field.
REQ-008 The block SHALL have the port hour  output  5  hours, binary, 0..23.
REQ-009 The block SHALL have the port min  output  6  minutes, binary, 0..59.
REQ-010 The block SHALL have the port sec  output  6  seconds, binary, 0..59.
REQ-011 The block SHALL have the port mode  output  2  current state: 0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.
REQ-012 The block SHALL have the port blank  output  3  per-field display blank, {hour,min,sec}.
REQ-013 The block SHALL have the port day_carry  output  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover.

Function
REQ-014 The state machine SHALL have states RUN, SET_HOUR, SET_MIN, SET_SEC, and mode SHALL equal the state encoding.
REQ-015 btn_mode SHALL cause these transitions, each on the next clk edge: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
REQ-016 In RUN, tick=1 SHALL increment sec; the fields SHALL update on the same clk edge that samples tick (1-cycle latency).
REQ-017 On sec=59 with a tick: sec SHALL become 0 and min SHALL increment; on min=59 with a carry: min SHALL become 0 and hour SHALL increment; on hour=23 with a carry: hour SHALL become 0.
REQ-018 day_carry SHALL be registered and high for exactly the one cycle following the 23:59:59 -> 00:00:00 update; it SHALL be 0 otherwise.
REQ-019 In SET_* states, tick SHALL be ignored (timekeeping paused) and day_carry SHALL remain 0.
REQ-020 In SET_x, btn_up SHALL increment field x modulo its range (23->0 for hour, 59->0 for min/sec), with no carry into other fields.
REQ-021 In SET_x, btn_down SHALL decrement field x modulo its range (0->23 for hour, 0->59 for min/sec), with no borrow.
REQ-022 Writing any value to sec in SET_SEC SHALL NOT reset the seconds phase; the next tick in RUN increments normally.
REQ-023 btn_up and btn_down together in one cycle SHALL leave all fields unchanged.
REQ-024 btn_mode together with btn_up/btn_down SHALL apply the mode change only; the field SHALL be unchanged.
REQ-025 btn_mode and tick together in RUN SHALL apply both: the increment with full carry, and the state advancing to SET_HOUR.
REQ-026 btn_up/btn_down in RUN SHALL be ignored.
REQ-027 blank bit for the selected field SHALL equal tick_blink combinationally; all other blank bits SHALL be 0; in RUN, blank SHALL be 3'b000.
REQ-028 Field registers SHALL never hold out-of-range values (hour>23, min/sec>59).

Reset
REQ-029 While rst=1: state=RUN, hour=0, min=0, sec=0, day_carry=0, and mode=0 immediately, without waiting for clk.
REQ-030 blank SHALL be 3'b000 during reset.
REQ-031 Reset asserted mid-edit SHALL discard the edit, and the block SHALL return to RUN at 00:00:00.
REQ-032 On the first clk edge after rst deasserts, normal operation SHALL resume.

Verification
REQ-033 Rollover scenario: RUN, 23:59:59, tick pulse -> next cycle 00:00:00, day_carry=1 for one cycle, then 0.
REQ-034 Carry-chain scenario: RUN, 10:59:59, tick -> 11:00:00, day_carry=0; 10:58:59, tick -> 10:59:00.
REQ-035 Edit-wrap scenario: btn_mode x1 (SET_HOUR), hour=0, btn_down -> hour=23; btn_mode, min=59, btn_up -> min=0, hour unchanged.
REQ-036 Paused-and-blink scenario: SET_MIN, 5 ticks -> sec unchanged; blank=3'b010 when tick_blink=1, 3'b000 when tick_blink=0.
REQ-037 Simultaneous-input scenario: SET_SEC, sec=30, btn_up+btn_down -> 30; btn_mode+btn_up -> mode=RUN, sec=30; RUN 12:00:59, tick+btn_mode -> 12:01:00, mode=SET_HOUR.
REQ-038 Async-reset scenario: rst pulsed between clk edges in SET_MIN at 07:45:12 -> outputs 00:00:00, mode=0 before the next edge.
